// File: rtl/regfile_write_arbiter_if.sv
// Bundle for the write-back arbiter: two requester handshakes, the register
// file write port, and the two bypassed read ports.
interface regfile_write_arbiter_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              a_valid;
   logic              a_ready;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_data;

   logic              b_valid;
   logic              b_ready;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_data;

   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;

   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [DATA_W-1:0] rf_rdata1;
   logic [DATA_W-1:0] rf_rdata2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;

   logic              busy;

   // Master is the pipeline/register-file side; slave is the arbiter.
   modport master (
      output a_valid, a_addr, a_data,
      output b_valid, b_addr, b_data,
      output rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
      input  a_ready, b_ready,
      input  rf_we, rf_waddr, rf_wdata,
      input  rd_data1, rd_data2, busy
   );

   modport slave (
      input  a_valid, a_addr, a_data,
      input  b_valid, b_addr, b_data,
      input  rd_addr1, rd_addr2, rf_rdata1, rf_rdata2,
      output a_ready, b_ready,
      output rf_we, rf_waddr, rf_wdata,
      output rd_data1, rd_data2, busy
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port between the ALU (A) and
// load (B) write-back paths, with read bypass of the in-flight write.
module regfile_write_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   regfile_write_arbiter_if.slave  bus
);

   logic              a_full;
   logic [ADDR_W-1:0] a_addr_q;
   logic [DATA_W-1:0] a_data_q;

   logic              b_full;
   logic [ADDR_W-1:0] b_addr_q;
   logic [DATA_W-1:0] b_data_q;

   // 0: A won the most recent grant, 1: B did (reset value favours A first)
   logic              last_grant;

   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;

   logic grant_a;
   logic grant_b;
   logic a_ready_c;
   logic b_ready_c;
   logic a_fill;
   logic b_fill;

   always_comb begin
      grant_a   = a_full && (!b_full || last_grant);
      grant_b   = b_full && (!a_full || !last_grant);
      a_ready_c = !a_full || grant_a;
      b_ready_c = !b_full || grant_b;
      // Writes to r0 are accepted but dropped here, so they never reach the port.
      a_fill    = bus.a_valid && a_ready_c && (bus.a_addr != '0);
      b_fill    = bus.b_valid && b_ready_c && (bus.b_addr != '0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_full   <= 1'b0;
         a_addr_q <= '0;
         a_data_q <= '0;
      end else if (a_fill) begin
         a_full   <= 1'b1;
         a_addr_q <= bus.a_addr;
         a_data_q <= bus.a_data;
      end else if (grant_a) begin
         a_full   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         b_full   <= 1'b0;
         b_addr_q <= '0;
         b_data_q <= '0;
      end else if (b_fill) begin
         b_full   <= 1'b1;
         b_addr_q <= bus.b_addr;
         b_data_q <= bus.b_data;
      end else if (grant_b) begin
         b_full   <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         last_grant <= 1'b1;
      end else if (grant_a) begin
         we_q       <= 1'b1;
         waddr_q    <= a_addr_q;
         wdata_q    <= a_data_q;
         last_grant <= 1'b0;
      end else if (grant_b) begin
         we_q       <= 1'b1;
         waddr_q    <= b_addr_q;
         wdata_q    <= b_data_q;
         last_grant <= 1'b1;
      end else begin
         we_q       <= 1'b0;
      end
   end

   // Only the write on the port this cycle is forwarded; buffered writes are
   // covered by busy, which the sequencer uses to stall dependent reads.
   function automatic logic [DATA_W-1:0] bypass(
      input logic [ADDR_W-1:0] raddr,
      input logic [DATA_W-1:0] rdata,
      input logic              we,
      input logic [ADDR_W-1:0] waddr,
      input logic [DATA_W-1:0] wdata
   );
      if (raddr == '0)
         return '0;
      else if (we && (waddr == raddr))
         return wdata;
      else
         return rdata;
   endfunction

   assign bus.a_ready  = a_ready_c;
   assign bus.b_ready  = b_ready_c;
   assign bus.rf_we    = we_q;
   assign bus.rf_waddr = waddr_q;
   assign bus.rf_wdata = wdata_q;
   assign bus.rd_data1 = bypass(bus.rd_addr1, bus.rf_rdata1, we_q, waddr_q, wdata_q);
   assign bus.rd_data2 = bypass(bus.rd_addr2, bus.rf_rdata2, we_q, waddr_q, wdata_q);
   assign bus.busy     = a_full || b_full || we_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: per-cycle vector table plus a
// hand-written mid-cycle reset and post-reset contention sequence.
module tb_regfile_write_arbiter;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int NVEC   = 25;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   regfile_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Register file: unwritten register r holds 0xF000_0000 | r; writes land on
   // the edge that ends an rf_we cycle.
   bit [31:0] regs [32];
   bit [31:0] written;

   always @(posedge clk) begin
      if (bus.rf_we) begin
         regs[bus.rf_waddr]    <= bus.rf_wdata;
         written[bus.rf_waddr] <= 1'b1;
      end
   end

   always_comb begin
      bus.rf_rdata1 = written[bus.rd_addr1] ? regs[bus.rd_addr1] : (32'hF000_0000 | 32'(bus.rd_addr1));
      bus.rf_rdata2 = written[bus.rd_addr2] ? regs[bus.rd_addr2] : (32'hF000_0000 | 32'(bus.rd_addr2));
   end

   typedef struct {
      logic        av;
      logic [4:0]  aa;
      logic [31:0] ad;
      logic        bv;
      logic [4:0]  ba;
      logic [31:0] bd;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic        ea;
      logic        eb;
      logic        ewe;
      logic [4:0]  ewa;
      logic [31:0] ewd;
      logic [31:0] ed1;
      logic [31:0] ed2;
      logic        ebusy;
   } vec_t;

   vec_t vecs [NVEC];

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.a_valid  = av;
      bus.a_addr   = aa;
      bus.a_data   = ad;
      bus.b_valid  = bv;
      bus.b_addr   = ba;
      bus.b_data   = bd;
      bus.rd_addr1 = r1;
      bus.rd_addr2 = r2;
   endtask

   initial begin
      //            av    aa     ad            bv    ba     bd            r1     r2       ea    eb    we    wa     wd            d1            d2            busy
      // A writes r0: consumed, nothing issues
      vecs[0]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd7,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        32'hF0000007, 1'b0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
      // Contention straight after reset: A first, B waits one cycle
      vecs[2]  = '{1'b1, 5'd10, 32'h11111111, 1'b1, 5'd15, 32'h22222222, 5'd0,  5'd0,    1'b1, 1'b1, 1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        1'b0};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd15,   1'b1, 1'b0, 1'b0, 5'd0,  32'h0,        32'hF000000A, 32'hF000000F, 1'b1};
      vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd15,   1'b1, 1'b1, 1'b1, 5'd10, 32'h11111111, 32'h11111111, 32'hF000000F, 1'b1};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd10, 5'd15,   1'b1, 1'b1, 1'b1, 5'd15, 32'h22222222, 32'h11111111, 32'h22222222, 1'b1};
      // Single A write: latency, bypass, busy fall
      vecs[6]  = '{1'b1, 5'd5,  32'h000000AA, 1'b0, 5'd0,  32'h0,        5'd15, 5'd0,    1'b1, 1'b1, 1'b0, 5'd15, 32'h22222222, 32'h22222222, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,    1'b1, 1'b1, 1'b0, 5'd15, 32'h22222222, 32'hF0000005, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd5,    1'b1, 1'b1, 1'b1, 5'd5,  32'h000000AA, 32'h000000AA, 32'h000000AA, 1'b1};
      vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd0,    1'b1, 1'b1, 1'b0, 5'd5,  32'h000000AA, 32'h000000AA, 32'h0,        1'b0};
      // Same destination r20 from A then B: later grant wins
      vecs[10] = '{1'b1, 5'd20, 32'h00000003, 1'b0, 5'd0,  32'h0,        5'd0,  5'd20,   1'b1, 1'b1, 1'b0, 5'd5,  32'h000000AA, 32'h0,        32'hF0000014, 1'b0};
      vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h00000004, 5'd0,  5'd20,   1'b1, 1'b1, 1'b0, 5'd5,  32'h000000AA, 32'h0,        32'hF0000014, 1'b1};
      vecs[12] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd20,   1'b1, 1'b1, 1'b1, 5'd20, 32'h00000003, 32'h0,        32'h00000003, 1'b1};
      vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd20,   1'b1, 1'b1, 1'b1, 5'd20, 32'h00000004, 32'h0,        32'h00000004, 1'b1};
      vecs[14] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd20,   1'b1, 1'b1, 1'b0, 5'd20, 32'h00000004, 32'h0,        32'h00000004, 1'b0};
      // Both streaming for 6 cycles: A1 B1 A2 B2 A3 B3 A4 back to back
      vecs[15] = '{1'b1, 5'd1,  32'h000000A1, 1'b1, 5'd2,  32'h000000B1, 5'd0,  5'd0,    1'b1, 1'b1, 1'b0, 5'd20, 32'h00000004, 32'h0,        32'h0,        1'b0};
      vecs[16] = '{1'b1, 5'd3,  32'h000000A2, 1'b1, 5'd4,  32'h000000B2, 5'd0,  5'd0,    1'b1, 1'b0, 1'b0, 5'd20, 32'h00000004, 32'h0,        32'h0,        1'b1};
      vecs[17] = '{1'b1, 5'd5,  32'h000000A3, 1'b1, 5'd4,  32'h000000B2, 5'd0,  5'd0,    1'b0, 1'b1, 1'b1, 5'd1,  32'h000000A1, 32'h0,        32'h0,        1'b1};
      vecs[18] = '{1'b1, 5'd5,  32'h000000A3, 1'b1, 5'd6,  32'h000000B3, 5'd0,  5'd0,    1'b1, 1'b0, 1'b1, 5'd2,  32'h000000B1, 32'h0,        32'h0,        1'b1};
      vecs[19] = '{1'b1, 5'd7,  32'h000000A4, 1'b1, 5'd6,  32'h000000B3, 5'd3,  5'd1,    1'b0, 1'b1, 1'b1, 5'd3,  32'h000000A2, 32'h000000A2, 32'h000000A1, 1'b1};
      vecs[20] = '{1'b1, 5'd7,  32'h000000A4, 1'b1, 5'd8,  32'h000000B4, 5'd0,  5'd0,    1'b1, 1'b0, 1'b1, 5'd4,  32'h000000B2, 32'h0,        32'h0,        1'b1};
      vecs[21] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,    1'b0, 1'b1, 1'b1, 5'd5,  32'h000000A3, 32'h0,        32'h0,        1'b1};
      vecs[22] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,    1'b1, 1'b1, 1'b1, 5'd6,  32'h000000B3, 32'h0,        32'h0,        1'b1};
      vecs[23] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd0,    1'b1, 1'b1, 1'b1, 5'd7,  32'h000000A4, 32'h0,        32'h0,        1'b1};
      vecs[24] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd7,  5'd20,   1'b1, 1'b1, 1'b0, 5'd7,  32'h000000A4, 32'h000000A4, 32'h00000004, 1'b0};

      reset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

      @(negedge clk);
      check("reset a_ready",  32'(bus.a_ready),  32'h1);
      check("reset b_ready",  32'(bus.b_ready),  32'h1);
      check("reset rf_we",    32'(bus.rf_we),    32'h0);
      check("reset rf_waddr", 32'(bus.rf_waddr), 32'h0);
      check("reset rf_wdata", bus.rf_wdata,      32'h0);
      check("reset busy",     32'(bus.busy),     32'h0);

      @(posedge clk);
      #2 reset = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd,
               vecs[i].r1, vecs[i].r2);
         @(negedge clk);
         check($sformatf("row%0d a_ready", i),  32'(bus.a_ready),  32'(vecs[i].ea));
         check($sformatf("row%0d b_ready", i),  32'(bus.b_ready),  32'(vecs[i].eb));
         check($sformatf("row%0d rf_we", i),    32'(bus.rf_we),    32'(vecs[i].ewe));
         check($sformatf("row%0d rf_waddr", i), 32'(bus.rf_waddr), 32'(vecs[i].ewa));
         check($sformatf("row%0d rf_wdata", i), bus.rf_wdata,      vecs[i].ewd);
         check($sformatf("row%0d rd_data1", i), bus.rd_data1,      vecs[i].ed1);
         check($sformatf("row%0d rd_data2", i), bus.rd_data2,      vecs[i].ed2);
         check($sformatf("row%0d busy", i),     32'(bus.busy),     32'(vecs[i].ebusy));
         @(posedge clk);
         #1;
      end

      // Fill both buffers, refill B on its grant, then reset mid rf_we cycle.
      drive(1'b1, 5'd9, 32'h00000099, 1'b1, 5'd11, 32'h000000BB, 5'd0, 5'd0);
      @(negedge clk);
      check("fill a_ready", 32'(bus.a_ready), 32'h1);
      check("fill b_ready", 32'(bus.b_ready), 32'h1);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h000000CC, 5'd0, 5'd0);
      @(negedge clk);
      check("refill a_ready", 32'(bus.a_ready), 32'h0);
      check("refill b_ready", 32'(bus.b_ready), 32'h1);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd9);
      @(negedge clk);
      check("pre-reset rf_we",    32'(bus.rf_we),    32'h1);
      check("pre-reset rf_waddr", 32'(bus.rf_waddr), 32'd11);
      check("pre-reset busy",     32'(bus.busy),     32'h1);
      reset = 1'b0;
      #1;
      check("mid reset rf_we",    32'(bus.rf_we),    32'h0);
      check("mid reset rf_waddr", 32'(bus.rf_waddr), 32'h0);
      check("mid reset rf_wdata", bus.rf_wdata,      32'h0);
      check("mid reset busy",     32'(bus.busy),     32'h0);
      check("mid reset a_ready",  32'(bus.a_ready),  32'h1);
      check("mid reset b_ready",  32'(bus.b_ready),  32'h1);
      @(posedge clk);
      @(posedge clk);
      #2 reset = 1'b1;

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("post-reset%0d rf_we", k), 32'(bus.rf_we), 32'h0);
         check($sformatf("post-reset%0d busy", k),  32'(bus.busy),  32'h0);
         @(posedge clk);
         #1;
      end
      check("lost write r11", bus.rd_data1, 32'hF000000B);
      check("lost write r9",  bus.rd_data2, 32'hF0000009);

      // last_grant was preferring A again after reset.
      drive(1'b1, 5'd13, 32'h000000D1, 1'b1, 5'd14, 32'h000000D2, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      @(negedge clk);
      check("after-reset a_ready", 32'(bus.a_ready), 32'h1);
      check("after-reset b_ready", 32'(bus.b_ready), 32'h0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("after-reset first rf_we",    32'(bus.rf_we),    32'h1);
      check("after-reset first rf_waddr", 32'(bus.rf_waddr), 32'd13);
      check("after-reset first rf_wdata", bus.rf_wdata,      32'h000000D1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("after-reset second rf_we",    32'(bus.rf_we),    32'h1);
      check("after-reset second rf_waddr", 32'(bus.rf_waddr), 32'd14);
      check("after-reset second rf_wdata", bus.rf_wdata,      32'h000000D2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between two write-back requesters: A, the ALU result path, and B, the memory-load path. Each requester has a valid/ready handshake and a one-entry holding buffer. A round-robin arbiter issues one registered write strobe per cycle to the register file. Read-port bypass muxes forward the in-flight write to the register file read outputs, so same-cycle read-after-write returns the new value.

## Interface
- ADDR_W, 5, register index width (32 registers)
- DATA_W, 32, register data width

- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A's buffer can accept this cycle
- a_addr  in  ADDR_W  A's destination register
- a_data  in  DATA_W  A's write data
- b_valid, b_ready, b_addr, b_data  same as A, for requester B
- rf_we  out  1  write strobe to register file, one cycle per write
- rf_waddr  out  ADDR_W  write address to register file
- rf_wdata  out  DATA_W  write data to register file
- rd_addr1, rd_addr2  in  ADDR_W  read addresses, also driven to the register file
- rf_rdata1, rf_rdata2  in  DATA_W  raw register file read data
- rd_data1, rd_data2  out  DATA_W  bypassed read data
- busy  out  1  a buffer is occupied or rf_we is high

## Operation
- Per-requester buffer state: full flag, addr, data. Shared state: last_grant flag (0 = A granted last, 1 = B granted last).
- Accept: x_valid && x_ready at an edge. If x_addr == 0, the request is consumed and discarded; the buffer is not filled and no write is issued.
- x_ready = !x_full || grant_x. This is combinational and depends only on buffer state and last_grant, never on x_valid.
- Grant, combinational each cycle:
  - Only A full: grant A.
  - Only B full: grant B.
  - Both full: grant the requester not granted last.
  - Neither full: no grant.
- On a grant edge:
  - rf_we <= 1, rf_waddr/rf_wdata <= the granted buffer's contents.
  - The granted buffer empties, unless a new accept refills it on the same edge.
  - last_grant updates.
- With no grant, rf_we <= 0 and rf_waddr/rf_wdata hold their values.
- Bypass for each port k, in priority order:
  - rd_addrk == 0 -> 0
  - rf_we && rf_waddr == rd_addrk -> rf_wdata
  - otherwise -> rf_rdatak
- Buffered, not-yet-granted writes are not forwarded. The sequencer uses busy to stall dependent reads.
- A and B buffers holding the same address are written in grant order; the later grant wins.

## Timing
- Reset asserted (async, low):
  - rf_we=0, rf_waddr=0, rf_wdata=0
  - both buffers empty, last_grant=1 (A preferred first)
  - a_ready=b_ready=1, busy=0
  - Any pending writes are lost.
- Reset deassertion is sampled at clock edges. The first accept can occur on the first edge after reset goes high.
- Latency: a request accepted at edge N into an empty buffer, with no competing full buffer, produces rf_we high for the cycle after edge N+1.
- Under contention, the losing requester waits exactly one extra cycle.
- Throughput:
  - Port: one write per cycle.
  - Single requester streaming alone: one write per cycle, since ready stays high via grant_x.
  - Both streaming: alternating A, B, A, B.
- Simultaneous accept and grant on the same requester: the buffer is refilled with the new entry; no bubble.
- Bypass paths are purely combinational; the register file must write on the clock edge that ends the rf_we cycle.

## Test plan
- Reset, then A writes addr 5 = 0x0000_00AA -> rf_we high for one cycle, addr 5, data 0xAA; busy falls the cycle after; rd_addr1=5 during the rf_we cycle returns 0xAA.
- A and B accepted on the same edge (addr 10 = 0x1111_1111, addr 15 = 0x2222_2222) -> A written first, then B on the next cycle; b_ready low for exactly one cycle.
- Both hold valid continuously for 6 cycles with distinct addresses -> writes alternate A, B, A, B, A, B; no cycle without rf_we after the first.
- A writes addr 0 = 0xDEAD_BEEF -> a_ready high, rf_we never asserts, busy stays 0; rd_data1 with rd_addr1=0 = 0.
- A and B both target addr 20 with 0x3 (A) then 0x4 (B) -> final register 20 = 0x4; rd_data2 at addr 20 shows 0x3, then 0x4, in the respective rf_we cycles.
- Reset asserted low mid-cycle while both buffers are full -> rf_we drops immediately; no writes issue after release; the next A/B contention grants A first.
